// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the SRAM slave's transfer-state enum.
// Imported by the slave top and its storage array.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE  = 3'b000;
  localparam logic [2:0] HSIZE_HALF  = 3'b001;
  localparam logic [2:0] HSIZE_WORD  = 3'b010;
  localparam logic [2:0] HSIZE_DWORD = 3'b011;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    ERR1 = 2'b10,
    ERR2 = 2'b11
  } state_e;

endpackage

// File: rtl/ahb_sram_mem.sv
// Word-organised storage: synchronous write with per-byte enables and a
// combinational read port. Contents are deliberately not reset.
module ahb_sram_mem
  import ahb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 256,
  localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1,
  localparam int BYTES = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [BYTES-1:0]      be,
  input  logic [IDX_W-1:0]      addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem_r [MEM_DEPTH];

  // Byte-lane write merge into the addressed word.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < BYTES; b++) begin
        if (be[b]) begin
          mem_r[addr][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

  assign rdata = mem_r[addr];

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM slave: address-phase checks, wait-state/error FSM and
// byte-enable generation around the ahb_sram_mem storage array.
module ahb_sram_slave
  import ahb_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  HSEL,
  input  logic [ADDR_WIDTH-1:0] HADDR,
  input  logic [1:0]            HTRANS,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [DATA_WIDTH-1:0] HWDATA,
  input  logic                  HREADY,
  output logic [DATA_WIDTH-1:0] HRDATA,
  output logic [1:0]            HRESP,
  output logic                  HREADYOUT
);

  localparam int BYTES  = DATA_WIDTH / 8;
  localparam int LANE_W = $clog2(BYTES);
  localparam int IDX_W  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int KEEP_W = LANE_W + IDX_W;
  localparam int CNT_W  = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);
  localparam logic [ADDR_WIDTH-LANE_W-1:0] DEPTH_L = (ADDR_WIDTH - LANE_W)'(MEM_DEPTH);

  state_e                state_r, state_s;
  logic [CNT_W-1:0]      cnt_r, cnt_s;
  logic                  pend_r, pend_s;
  logic [KEEP_W-1:0]     addr_r;
  logic                  write_r;
  logic [2:0]            size_r;
  logic                  err_r;
  logic                  sample_s, err_s, complete_s, mem_we_s;
  logic [BYTES-1:0]      be_s;
  logic [DATA_WIDTH-1:0] rdata_s;

  function automatic logic addr_misaligned(input logic [LANE_W-1:0] low, input logic [2:0] size);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < LANE_W; i++) begin
      bad = bad | (low[i] & (i < int'(size)));
    end
    return bad;
  endfunction

  // Little-endian lanes covered by a naturally aligned transfer.
  function automatic logic [BYTES-1:0] lane_enables(input logic [LANE_W-1:0] low, input logic [2:0] size);
    logic [BYTES-1:0] be;
    int first;
    int last;
    first = int'(low);
    last  = first + int'(32'd1 << size);
    for (int b = 0; b < BYTES; b++) begin
      be[b] = (b >= first) && (b < last);
    end
    return be;
  endfunction

  assign sample_s = HSEL && HREADY && ((HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ))
                    && ((state_r == IDLE) || (state_r == ERR2));
  assign err_s = (HSIZE > 3'(LANE_W))
                 || addr_misaligned(HADDR[LANE_W-1:0], HSIZE)
                 || (HADDR[ADDR_WIDTH-1:LANE_W] >= DEPTH_L);
  assign complete_s = pend_r && (state_r == IDLE);
  assign mem_we_s   = complete_s && write_r && !err_r;
  assign be_s       = lane_enables(addr_r[LANE_W-1:0], size_r);

  // State, wait counter and address-phase control registers.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_r <= IDLE;
      cnt_r   <= {CNT_W{1'b0}};
      pend_r  <= 1'b0;
      addr_r  <= {KEEP_W{1'b0}};
      write_r <= 1'b0;
      size_r  <= 3'b000;
      err_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      pend_r  <= pend_s;
      if (sample_s) begin
        addr_r  <= HADDR[KEEP_W-1:0];
        write_r <= HWRITE;
        size_r  <= HSIZE;
        err_r   <= err_s;
      end
    end
  end

  // Next-state: a data phase is pending in IDLE (zero-wait) or after WAIT drains.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    pend_s  = pend_r;
    case (state_r)
      IDLE, ERR2: begin
        if (sample_s && err_s) begin
          state_s = ERR1;
          pend_s  = 1'b0;
        end else if (sample_s && (WAIT_STATES > 0)) begin
          state_s = WAIT;
          cnt_s   = CNT_LOAD;
          pend_s  = 1'b1;
        end else if (sample_s) begin
          state_s = IDLE;
          pend_s  = 1'b1;
        end else begin
          state_s = IDLE;
          pend_s  = 1'b0;
        end
      end
      WAIT: begin
        if (cnt_r == {CNT_W{1'b0}}) begin
          state_s = IDLE;
        end else begin
          cnt_s = cnt_r - CNT_W'(1'b1);
        end
      end
      ERR1: begin
        state_s = ERR2;
      end
      default: begin
        state_s = IDLE;
        pend_s  = 1'b0;
      end
    endcase
  end

  // Response decode from the registered state.
  always_comb begin
    HREADYOUT = 1'b1;
    HRESP     = HRESP_OKAY;
    case (state_r)
      WAIT:    HREADYOUT = 1'b0;
      ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = HRESP_ERROR;
      end
      ERR2:    HRESP = HRESP_ERROR;
      default: HREADYOUT = 1'b1;
    endcase
    HRDATA = (complete_s && !write_r) ? rdata_s : {DATA_WIDTH{1'b0}};
  end

  ahb_sram_mem #(
    .DATA_WIDTH(DATA_WIDTH),
    .MEM_DEPTH (MEM_DEPTH)
  ) u_mem (
    .clk  (HCLK),
    .we   (mem_we_s),
    .be   (be_s),
    .addr (addr_r[KEEP_W-1:LANE_W]),
    .wdata(HWDATA),
    .rdata(rdata_s)
  );

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Directed bench: a zero-wait and a two-wait-state slave share one stimulus bus;
// 'which' selects the slave under test.
module tb_ahb_sram_slave;
  import ahb_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        which;
  logic        h_sel;
  logic [31:0] h_addr;
  logic [1:0]  h_trans;
  logic        h_write;
  logic [2:0]  h_size;
  logic [31:0] h_wdata;
  logic [31:0] rd0, rd2;
  logic [1:0]  rs0, rs2;
  logic        rdy0, rdy2;
  logic        o_ready;
  logic [31:0] o_rdata;
  logic [1:0]  o_resp;
  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  assign o_ready = which ? rdy2 : rdy0;
  assign o_rdata = which ? rd2 : rd0;
  assign o_resp  = which ? rs2 : rs0;

  ahb_sram_slave #(.WAIT_STATES(0)) u_dut0 (
    .HCLK(clk), .HRESETn(rst_n), .HSEL(h_sel && !which), .HADDR(h_addr),
    .HTRANS(h_trans), .HWRITE(h_write), .HSIZE(h_size), .HWDATA(h_wdata),
    .HREADY(rdy0), .HRDATA(rd0), .HRESP(rs0), .HREADYOUT(rdy0)
  );

  ahb_sram_slave #(.WAIT_STATES(2)) u_dut2 (
    .HCLK(clk), .HRESETn(rst_n), .HSEL(h_sel && which), .HADDR(h_addr),
    .HTRANS(h_trans), .HWRITE(h_write), .HSIZE(h_size), .HWDATA(h_wdata),
    .HREADY(rdy2), .HRDATA(rd2), .HRESP(rs2), .HREADYOUT(rdy2)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One isolated transfer; reports data/response seen in the completing cycle.
  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                      input logic [31:0] wd, output logic [31:0] rd,
                      output logic [1:0] resp_first, output logic [1:0] resp_last,
                      output int waits);
    h_sel = 1'b1; h_addr = addr; h_write = wr; h_size = size; h_trans = HTRANS_NONSEQ;
    cyc();
    h_sel = 1'b0; h_trans = HTRANS_IDLE; h_wdata = wd;
    waits = 0;
    resp_first = o_resp;
    while (!o_ready && waits < 32) begin
      waits++;
      cyc();
    end
    rd = o_rdata;
    resp_last = o_resp;
    n_total++;
    if (waits >= 32) $display("FAIL xfer_timeout addr=%h: still waiting after %0d cycles, required completion", addr, waits);
    else n_pass++;
    cyc();
    h_wdata = 32'h0;
  endtask

  task automatic test_reset();
    n_total++;
    if ({rdy0, rs0} !== 3'b100) $display("FAIL reset_resp0: got rdy/resp=%b required 100", {rdy0, rs0});
    else n_pass++;
    n_total++;
    if (rd0 !== 32'h0) $display("FAIL reset_rdata0: got %h required 00000000", rd0);
    else n_pass++;
    n_total++;
    if ({rdy2, rs2} !== 3'b100) $display("FAIL reset_resp2: got rdy/resp=%b required 100", {rdy2, rs2});
    else n_pass++;
    n_total++;
    if (rd2 !== 32'h0) $display("FAIL reset_rdata2: got %h required 00000000", rd2);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic low_seen;
    which = 1'b0;
    low_seen = !o_ready;
    h_sel = 1'b1; h_addr = 32'h4; h_write = 1'b1; h_size = HSIZE_WORD; h_trans = HTRANS_NONSEQ;
    cyc();
    low_seen = low_seen | !o_ready;
    n_total++;
    if (o_rdata !== 32'h0) $display("FAIL b2b_write_rdata: got %h required 00000000", o_rdata);
    else n_pass++;
    h_wdata = 32'hDEADBEEF; h_write = 1'b0;
    cyc();
    low_seen = low_seen | !o_ready;
    h_sel = 1'b0; h_trans = HTRANS_IDLE;
    n_total++;
    if (o_rdata !== 32'hDEADBEEF || o_resp !== HRESP_OKAY)
      $display("FAIL b2b_read: got data=%h resp=%b required DEADBEEF/00", o_rdata, o_resp);
    else n_pass++;
    cyc();
    low_seen = low_seen | !o_ready;
    n_total++;
    if (low_seen !== 1'b0) $display("FAIL b2b_ready: got HREADYOUT low=%b required 0", low_seen);
    else n_pass++;
    n_total++;
    if (o_rdata !== 32'h0) $display("FAIL b2b_idle_rdata: got %h required 00000000", o_rdata);
    else n_pass++;
  endtask

  task automatic test_byte_lanes();
    logic [31:0] rd;
    logic [1:0] r1, r2;
    int w;
    which = 1'b0;
    xfer(1'b1, 32'h8, HSIZE_WORD, 32'h11223344, rd, r1, r2, w);
    xfer(1'b1, 32'h9, HSIZE_BYTE, 32'h0000AA00, rd, r1, r2, w);
    xfer(1'b0, 32'h8, HSIZE_WORD, 32'h0, rd, r1, r2, w);
    n_total++;
    if (rd !== 32'h1122AA44) $display("FAIL byte_lane: got %h required 1122AA44", rd);
    else n_pass++;
    xfer(1'b1, 32'hA, HSIZE_HALF, 32'hBEEF0000, rd, r1, r2, w);
    xfer(1'b0, 32'h8, HSIZE_WORD, 32'h0, rd, r1, r2, w);
    n_total++;
    if (rd !== 32'hBEEFAA44 || w !== 0) $display("FAIL half_lane: got %h waits=%0d required BEEFAA44 waits=0", rd, w);
    else n_pass++;
  endtask

  task automatic test_wait_states();
    logic [31:0] rd;
    logic [1:0] r1, r2;
    int w;
    which = 1'b1;
    xfer(1'b1, 32'h0, HSIZE_WORD, 32'hCAFEF00D, rd, r1, r2, w);
    n_total++;
    if (w !== 2) $display("FAIL ws_write_waits: got %0d required 2", w);
    else n_pass++;
    xfer(1'b0, 32'h0, HSIZE_WORD, 32'h0, rd, r1, r2, w);
    n_total++;
    if (w !== 2) $display("FAIL ws_read_waits: got %0d required 2", w);
    else n_pass++;
    n_total++;
    if (rd !== 32'hCAFEF00D || r1 !== HRESP_OKAY || r2 !== HRESP_OKAY)
      $display("FAIL ws_read: got data=%h resp=%b/%b required CAFEF00D 00/00", rd, r1, r2);
    else n_pass++;
  endtask

  task automatic test_error();
    logic [31:0] rd;
    logic [1:0] r1, r2;
    int w;
    which = 1'b0;
    xfer(1'b1, 32'h0, HSIZE_WORD, 32'hA0A0A0A0, rd, r1, r2, w);
    xfer(1'b1, 32'hC, HSIZE_WORD, 32'h0C0C0C0C, rd, r1, r2, w);
    xfer(1'b1, 32'h2, HSIZE_WORD, 32'hFFFFFFFF, rd, r1, r2, w);
    n_total++;
    if (w !== 1 || r1 !== HRESP_ERROR || r2 !== HRESP_ERROR)
      $display("FAIL err_misaligned: got waits=%0d resp=%b/%b required 1 01/01", w, r1, r2);
    else n_pass++;
    xfer(1'b0, 32'h400, HSIZE_WORD, 32'h0, rd, r1, r2, w);
    n_total++;
    if (w !== 1 || r1 !== HRESP_ERROR || r2 !== HRESP_ERROR || rd !== 32'h0)
      $display("FAIL err_range: got waits=%0d resp=%b/%b data=%h required 1 01/01 00000000", w, r1, r2, rd);
    else n_pass++;
    xfer(1'b0, 32'h0, HSIZE_DWORD, 32'h0, rd, r1, r2, w);
    n_total++;
    if (w !== 1 || r2 !== HRESP_ERROR) $display("FAIL err_size: got waits=%0d resp=%b required 1 01", w, r2);
    else n_pass++;
    xfer(1'b0, 32'h0, HSIZE_WORD, 32'h0, rd, r1, r2, w);
    n_total++;
    if (rd !== 32'hA0A0A0A0 || r2 !== HRESP_OKAY) $display("FAIL err_no_write: got %h resp=%b required A0A0A0A0 00", rd, r2);
    else n_pass++;
  endtask

  task automatic test_pipeline();
    logic [1:0]  tr [7] = '{HTRANS_NONSEQ, HTRANS_SEQ, HTRANS_BUSY, HTRANS_SEQ, HTRANS_IDLE, HTRANS_SEQ, HTRANS_IDLE};
    logic [31:0] ad [7] = '{32'h0, 32'h4, 32'h8, 32'h8, 32'hC, 32'hC, 32'h0};
    logic [31:0] ex [7] = '{32'hA0A0A0A0, 32'hDEADBEEF, 32'h0, 32'hBEEFAA44, 32'h0, 32'h0C0C0C0C, 32'h0};
    which = 1'b0;
    h_sel = 1'b1; h_write = 1'b0; h_size = HSIZE_WORD;
    for (int i = 0; i < 7; i++) begin
      h_trans = tr[i]; h_addr = ad[i];
      cyc();
      n_total++;
      if (o_rdata !== ex[i] || o_ready !== 1'b1 || o_resp !== HRESP_OKAY)
        $display("FAIL pipe_step%0d: got data=%h rdy=%b resp=%b required %h 1 00", i, o_rdata, o_ready, o_resp, ex[i]);
      else n_pass++;
    end
    h_sel = 1'b0; h_trans = HTRANS_IDLE;
  endtask

  task automatic test_reset_mid_wait();
    logic [31:0] rd;
    logic [1:0] r1, r2;
    int w;
    which = 1'b1;
    xfer(1'b1, 32'h10, HSIZE_WORD, 32'h55AA55AA, rd, r1, r2, w);
    h_sel = 1'b1; h_addr = 32'h10; h_write = 1'b1; h_size = HSIZE_WORD; h_trans = HTRANS_NONSEQ;
    cyc();
    h_sel = 1'b0; h_trans = HTRANS_IDLE; h_wdata = 32'h12345678;
    n_total++;
    if (o_ready !== 1'b0) $display("FAIL rst_in_wait: got HREADYOUT=%b required 0", o_ready);
    else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_total++;
    if ({rdy2, rs2} !== 3'b100 || rd2 !== 32'h0)
      $display("FAIL rst_async: got rdy/resp=%b data=%h required 100 00000000", {rdy2, rs2}, rd2);
    else n_pass++;
    @(posedge clk);
    #1 rst_n = 1'b1;
    h_wdata = 32'h0;
    cyc();
    xfer(1'b0, 32'h10, HSIZE_WORD, 32'h0, rd, r1, r2, w);
    n_total++;
    if (rd !== 32'h55AA55AA) $display("FAIL rst_write_dropped: got %h required 55AA55AA", rd);
    else n_pass++;
  endtask

  initial begin
    rst_n = 1'b0; which = 1'b0; h_sel = 1'b0; h_addr = 32'h0; h_trans = HTRANS_IDLE;
    h_write = 1'b0; h_size = HSIZE_WORD; h_wdata = 32'h0;
    #3;
    test_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    cyc();
    test_back_to_back();
    test_byte_lanes();
    test_wait_states();
    test_error();
    test_pipeline();
    test_reset_mid_wait();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/ahb_sram_slave.md
Name: ahb_sram_slave

Overview:
- AHB-Lite slave: word-organised on-chip SRAM with byte-lane writes, configurable wait states and a two-cycle ERROR response.
- Sits directly upstream of the response mux; HRDATA/HRESP/HREADYOUT connect to one HRDATAx/HRESPx/HREADYx slot; HSEL comes from the address decoder.
- Forms the standard memory peripheral on slot 0 of the bus fabric.

Parameters:
- ADDR_WIDTH, 32, HADDR width.
- DATA_WIDTH, 32, HRDATA/HWDATA width; must be 32 or 64.
- MEM_DEPTH, 256, number of DATA_WIDTH words.
- WAIT_STATES, 0, HREADYOUT-low cycles inserted before each OKAY completion; range 0..15.

Ports:
- HCLK  in  1  bus clock
- HRESETn  in  1  reset
- HSEL  in  1  slave select from the address decoder
- HADDR  in  ADDR_WIDTH  byte address
- HTRANS  in  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
- HWRITE  in  1  1 = write
- HSIZE  in  3  log2(bytes)
- HWDATA  in  DATA_WIDTH  write data, data phase
- HREADY  in  1  global bus HREADY, returned from the mux
- HRDATA  out  DATA_WIDTH  read data
- HRESP  out  2  00 OKAY, 01 ERROR
- HREADYOUT  out  1  slave ready

Interface decision: reset HRESETn, asynchronous, active-low; clock HCLK.

Behaviour:
- Reset values: HREADYOUT=1, HRESP=00, HRDATA=0, FSM=IDLE, wait counter=0, latched control=0. Memory contents are not reset.
- Address-phase sample occurs when HSEL && HREADY && HTRANS[1]=1. It latches addr_q, write_q, size_q and err_q. Without a sample, the next cycle is a zero-wait OKAY (IDLE/BUSY/unselected).
- err_q is set when any of these holds:
  - HSIZE > log2(DATA_WIDTH/8);
  - HADDR is misaligned for HSIZE;
  - the word index HADDR[..:log2(DATA_WIDTH/8)] >= MEM_DEPTH.
- FSM states: IDLE, WAIT, ERR1, ERR2.
- IDLE + sample:
  - err → ERR1;
  - WAIT_STATES>0 → WAIT, counter loaded with WAIT_STATES-1;
  - otherwise the data phase completes in the next cycle (DATA, HREADYOUT=1).
- WAIT: HREADYOUT=0, HRESP=OKAY. The counter decrements; at 0 the next cycle is the completion cycle.
- ERR1: HREADYOUT=0, HRESP=01.
- ERR2: HREADYOUT=1, HRESP=01.
- No memory access occurs on error; an error write discards HWDATA.
- Completion cycle (HREADYOUT=1, OKAY):
  - Read: HRDATA = mem[addr_q word] combinationally.
  - Write: HWDATA is written at the closing edge using byte enables from size_q/addr_q low bits (little-endian).
  - HRDATA=0 in every cycle that is not a read completion.
- Pipelining: a new address phase may be sampled in the completion cycle (HREADY high) and starts the next data phase with no bubble. This includes sampling during ERR2 per AHB rules.
- Read-after-write to the same address, back-to-back, returns the new data with no forwarding, because the write commits before the read data phase.
- HSEL low during a pending data phase: the transfer still completes normally.
- HTRANS=IDLE/BUSY while HREADY is low: ignored.
- Asynchronous reset mid-transfer: all state returns to reset values immediately; a pending write is dropped and memory keeps prior contents.
- Wait counter width is $clog2(WAIT_STATES+1), minimum 1.

Decomposition:
- Shared package ahb_pkg holds:
  - HTRANS codes;
  - HSIZE codes;
  - HRESP codes (OKAY=2'b00, ERROR=2'b01);
  - FSM state enum {IDLE, WAIT, ERR1, ERR2}.
- Sub-module ahb_sram_mem is the storage array: synchronous write with per-byte enables, combinational read port, parameters DATA_WIDTH and MEM_DEPTH.
- FSM, address checks and byte-enable generation live in ahb_sram_slave.

Test Plan:
- Reset: assert HRESETn=0 mid-WAIT → HREADYOUT=1, HRESP=00, HRDATA=0 asynchronously; the earlier write to 0x10 is not committed.
- WAIT_STATES=0: NONSEQ write 0x0000_0004=0xDEADBEEF, then NONSEQ read 0x4 back-to-back → read data phase returns 0xDEADBEEF, HREADYOUT never low.
- Byte lanes: word 0x8=0x11223344; HSIZE=0 write 0xAA to 0x9 → read 0x8 returns 0x1122AA44.
- WAIT_STATES=2: read 0x0 → HREADYOUT low for exactly 2 cycles, then high with data and HRESP=00.
- Error: HSIZE=2 at 0x2 (misaligned), and a read of 0x400 with MEM_DEPTH=256 → each gives HREADYOUT=0/HRESP=01, then HREADYOUT=1/HRESP=01; memory is unchanged.
- Pipelining: an SEQ burst of 4 reads 0x0..0xC with an IDLE and a BUSY inserted → 4 OKAY completions in order; IDLE/BUSY cycles show zero-wait OKAY with HRDATA=0.
